// File: rtl/cdr_phase_pkg.sv
// Shared helpers for the parametrised CDR phase generator: index width and phase-word pattern.
package cdr_phase_pkg;

  // Widest phase word the pattern helper can produce; callers truncate to their N.
  localparam int unsigned MAX_N = 64;

  // Index width for an index space of 2N (N a power of two).
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  // Johnson/thermometer word for index k: low k bits set up to N, then ones drain from the bottom.
  function automatic logic [MAX_N-1:0] phase_pattern(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] w;
    w = '0;
    for (int i = 0; i < int'(MAX_N); i++) begin
      if (i < int'(n)) begin
        if (idx <= n) w[i] = (i < int'(idx));
        else          w[i] = (i >= int'(idx - n));
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/phase_generator_param_if.sv
// Control/status bundle between the CDR loop filter (master) and the phase generator (slave).
interface phase_generator_param_if
  import cdr_phase_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned STEP_W = 2
);
  localparam int unsigned IDX_W = idx_width(N);

  logic              load;
  logic [IDX_W-1:0]  load_idx;
  logic              en;
  logic              dir;
  logic [STEP_W-1:0] step;
  logic [IDX_W-1:0]  phase_idx;
  logic [N-1:0]      phase_out;
  logic              wrap;

  modport master (
    output load, load_idx, en, dir, step,
    input  phase_idx, phase_out, wrap
  );

  modport slave (
    input  load, load_idx, en, dir, step,
    output phase_idx, phase_out, wrap
  );
endinterface

// File: rtl/phase_decode.sv
// Combinational phase index -> N-bit Johnson/thermometer phase word.
module phase_decode
  import cdr_phase_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic [idx_width(N)-1:0] idx,
  output logic [N-1:0]            word_c
);

  // Decode through the shared pattern helper so the word definition lives in one place.
  always_comb begin
    word_c = N'(phase_pattern(32'(idx), N));
  end

endmodule

// File: rtl/phase_generator_param.sv
// Parametrised CDR phase generator: phase index with direction, step, load, optional saturation.
module phase_generator_param
  import cdr_phase_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned STEP_W   = 2,
  parameter int unsigned SATURATE = 0
) (
  input logic                   clk,
  input logic                   rst_gen,
  phase_generator_param_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(N);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     phase_q, phase_d;
  logic             wrap_q, wrap_d;
  logic [SUM_W-1:0] step_ext;
  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] diff_c;

  // Next index and wrap flag; 2N is a power of two so the extra bit is the carry/borrow.
  always_comb begin
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    step_ext = SUM_W'(bus.step);
    sum_c    = {1'b0, idx_q} + step_ext;
    diff_c   = {1'b0, idx_q} - step_ext;
    if (bus.load) begin
      idx_d = bus.load_idx;
    end else if (bus.en && (bus.step != '0)) begin
      if (!bus.dir) begin
        wrap_d = sum_c[IDX_W];
        if ((SATURATE != 0) && sum_c[IDX_W]) idx_d = '1;
        else                                  idx_d = sum_c[IDX_W-1:0];
      end else begin
        wrap_d = diff_c[IDX_W];
        if ((SATURATE != 0) && diff_c[IDX_W]) idx_d = '0;
        else                                   idx_d = diff_c[IDX_W-1:0];
      end
    end
  end

  // Decode the next index so the word register tracks the index register with no lag.
  phase_decode #(.N(N)) u_decode (
    .idx    (idx_d),
    .word_c (phase_d)
  );

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_gen) begin
      idx_q   <= '0;
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.phase_idx = idx_q;
  assign bus.phase_out = phase_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: doc/phase_generator_param.md
Name: phase_generator_param

Overview:
Parametrised successor to the 16-phase generator used by the CDR loop.
- Keeps a phase index k in 0..2N-1 and drives an N-bit Johnson/thermometer phase word for the sampler clock-select network.
- Adds direction control, a variable step size, index load, optional saturation and a wrap flag, so the CDR loop filter can advance or retard phase directly instead of free-running.

Parameters:
N, 16, phase-word width; power of two, N >= 2; index space is 2N.
STEP_W, 2, width of step input; step range 0..2^STEP_W-1, must be < 2N.
SATURATE, 0, 0 = index wraps modulo 2N; 1 = index clamps at 0 and 2N-1.
IDX_W (localparam), log2(N)+1, phase index width.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_gen  in  1  synchronous active-high reset.
load  in  1  load phase index from load_idx.
load_idx  in  IDX_W  index to load.
en  in  1  apply one step this cycle.
dir  in  1  0 = advance (index + step), 1 = retard (index - step).
step  in  STEP_W  step magnitude; 0 = hold.
phase_idx  out  IDX_W  current phase index (registered).
phase_out  out  N  phase word for phase_idx (registered).
wrap  out  1  one-cycle pulse: last update crossed the 2N-1/0 boundary, or was clamped when SATURATE=1.

Behaviour:
- One clock, synchronous active-high reset. Priority per edge: rst_gen > load > en. All outputs are registered.
- Reset: phase_idx = 0, phase_out = 0, wrap = 0. The first update can occur on the first edge after rst_gen deasserts.
- Pattern(k):
  - k <= N: bits [k-1:0] = 1, others 0. k = 0 gives all zeros; k = N gives all ones.
  - k > N: bits [N-1:k-N] = 1, others 0. k = 2N-1 gives only bit N-1 set.
- phase_out always equals Pattern(phase_idx) of the same cycle. idx and word update on the same edge, with no one-cycle lag.
- load=1: phase_idx <= load_idx, phase_out <= Pattern(load_idx), wrap <= 0. en, dir and step are ignored.
- en=1, load=0, SATURATE=0:
  - next = (idx ± step) mod 2N, computed in IDX_W+1 bits and truncated.
  - wrap <= 1 if dir=0 and idx+step >= 2N, or dir=1 and step > idx.
- en=1, load=0, SATURATE=1:
  - next = min(idx+step, 2N-1) or max(idx-step, 0).
  - wrap <= 1 only when the clamp changed the result.
- en=1 with step=0: hold, wrap <= 0.
- en=0, load=0: hold idx and word, wrap <= 0.
- wrap is a single-cycle pulse; consecutive wrapping steps give consecutive pulses.
- Reset mid-operation: the next edge forces the reset values regardless of load/en. No pending state survives.
- Degenerate N=16, STEP_W=1, dir=0, en held 1: reproduces the legacy 32-state sequence. The legacy block's extra zero cycle after reset is not replicated.

Decomposition:
- Shared package cdr_phase_pkg: IDX_W computation function and a pattern function phase_pattern(idx, N). The function is reused by the bench scoreboard.
- One natural sub-module: phase_decode, combinational idx -> N-bit word, instantiated once on next_idx ahead of the output register.
- The index update (wrap/clamp arithmetic) stays in the top module.

Test Plan:
- Reset then free-run, N=16, en=1, dir=0, step=1 for 34 cycles -> phase_idx 1,2,...,31,0,1,2. phase_out 0x0001,0x0003,...,0xFFFF (idx16),0xFFFE,...,0x8000 (idx31),0x0000. wrap=1 only on the cycle idx becomes 0.
- load_idx=30, then en=1, dir=0, step=3 -> idx=1, phase_out=0x0001, wrap=1. Next cycle en=0 -> hold, wrap=0.
- From idx=0: en=1, dir=1, step=1 -> idx=31, phase_out=0x8000, wrap=1. Then step=2 -> idx=29, phase_out=0xE000, wrap=0.
- load=1 with en=1, dir=0, step=3, load_idx=16 -> idx=16, phase_out=0xFFFF, wrap=0 (load wins). en with step=0 -> no change.
- SATURATE=1 build:
  - idx=30, advance step=3 -> idx=31, phase_out=0x8000, wrap=1.
  - idx=1, retard step=2 -> idx=0, phase_out=0x0000, wrap=1.
- Mid-run reset: rst_gen=1 asserted together with load=1, load_idx=20 -> idx=0, phase_out=0, wrap=0. Then N=8 build free-run -> 16-state sequence matching phase_pattern.
